// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush-to-bubble and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_jump,
    input  logic              id_RegDst,
    input  logic              id_Branch,
    input  logic              id_BNE,
    input  logic              id_MemR,
    input  logic              id_Mem2R,
    input  logic              id_MemW,
    input  logic              id_RegW,
    input  logic              id_Alusrc,
    input  logic              id_jal,
    input  logic              id_jr,
    input  logic [1:0]        id_ExtOp,
    input  logic [4:0]        id_Aluctrl,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic              ex_jump,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic              ex_BNE,
    output logic              ex_MemR,
    output logic              ex_Mem2R,
    output logic              ex_MemW,
    output logic              ex_RegW,
    output logic              ex_Alusrc,
    output logic              ex_jal,
    output logic              ex_jr,
    output logic [1:0]        ex_ExtOp,
    output logic [4:0]        ex_Aluctrl,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [RA_W-1:0]   ex_dst,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int CTRL_W = 18;
    localparam int DAT_W  = 3*RA_W + 5 + 4*DATA_W;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DAT_W-1:0]  r_data;
    logic [RA_W-1:0]   r_dst;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DAT_W-1:0]  w_data;
    logic [RA_W-1:0]   w_dst;
    logic              w_uses_rs, w_uses_rt, w_hazard, w_bubble;

    assign w_ctrl = {id_jump, id_RegDst, id_Branch, id_BNE, id_MemR, id_Mem2R, id_MemW,
                     id_RegW, id_Alusrc, id_jal, id_jr, id_ExtOp, id_Aluctrl};
    assign w_data = {id_rs, id_rt, id_rd, id_shamt, id_rs_data, id_rt_data, id_imm, id_pc4};
    assign w_dst  = id_jal ? RA_W'(31) : id_RegDst ? id_rd : id_rt;

    // A plain jump carries no register operands; jr reads rs.
    assign w_uses_rs = !(id_jump && !id_jr);
    assign w_uses_rt = id_RegDst | id_MemW | id_Branch | id_BNE;
    assign w_hazard  = r_valid & ex_MemR & ex_RegW & (r_dst != '0) & id_valid &
                       ((w_uses_rs & (id_rs == r_dst)) | (w_uses_rt & (id_rt == r_dst)));
    assign stall_o   = w_hazard & !flush;
    assign w_bubble  = flush | w_hazard;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_dst   <= '0;
        end else begin
            r_valid <= id_valid;
            r_ctrl  <= id_valid ? w_ctrl : '0;
            r_data  <= w_data;
            r_dst   <= w_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_bubble && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign {ex_jump, ex_RegDst, ex_Branch, ex_BNE, ex_MemR, ex_Mem2R, ex_MemW,
            ex_RegW, ex_Alusrc, ex_jal, ex_jr, ex_ExtOp, ex_Aluctrl} = r_ctrl;
    assign {ex_rs, ex_rt, ex_rd, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc4} = r_data;
    assign ex_valid   = r_valid;
    assign ex_dst     = r_dst;
    assign bubble_cnt = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table-driven bench for id_ex_stage (bubble counter built 2 bits wide).
module tb_id_ex_stage;
    localparam int DW = 32, RW = 5, CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          id_valid, id_jump, id_RegDst, id_Branch, id_BNE, id_MemR, id_Mem2R;
    logic          id_MemW, id_RegW, id_Alusrc, id_jal, id_jr, flush;
    logic [1:0]    id_ExtOp;
    logic [4:0]    id_Aluctrl, id_shamt;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
    logic          stall_o, ex_valid, ex_jump, ex_RegDst, ex_Branch, ex_BNE, ex_MemR, ex_Mem2R;
    logic          ex_MemW, ex_RegW, ex_Alusrc, ex_jal, ex_jr;
    logic [1:0]    ex_ExtOp;
    logic [4:0]    ex_Aluctrl, ex_shamt;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd, ex_dst;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [CW-1:0] bubble_cnt;

    id_ex_stage #(.DATA_W(DW), .RA_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_jump(id_jump), .id_RegDst(id_RegDst),
        .id_Branch(id_Branch), .id_BNE(id_BNE), .id_MemR(id_MemR), .id_Mem2R(id_Mem2R),
        .id_MemW(id_MemW), .id_RegW(id_RegW), .id_Alusrc(id_Alusrc), .id_jal(id_jal),
        .id_jr(id_jr), .id_ExtOp(id_ExtOp), .id_Aluctrl(id_Aluctrl), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_jump(ex_jump), .ex_RegDst(ex_RegDst),
        .ex_Branch(ex_Branch), .ex_BNE(ex_BNE), .ex_MemR(ex_MemR), .ex_Mem2R(ex_Mem2R),
        .ex_MemW(ex_MemW), .ex_RegW(ex_RegW), .ex_Alusrc(ex_Alusrc), .ex_jal(ex_jal),
        .ex_jr(ex_jr), .ex_ExtOp(ex_ExtOp), .ex_Aluctrl(ex_Aluctrl), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_dst(ex_dst),
        .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        string         name;
        logic          v, fl, jump, jal, regdst, memr, memw, regw, alusrc;
        logic [RW-1:0] rs, rt, rd;
        logic [DW-1:0] imm;
        logic          e_stall, e_valid, e_regw, e_memr;
        logic [RW-1:0] e_dst;
        logic [DW-1:0] e_imm;
        logic [CW-1:0] e_cnt;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t t[15];

    function automatic vec_t mk(string name, logic v, logic fl, logic jump, logic jal,
                                logic regdst, logic memr, logic memw, logic regw, logic alusrc,
                                logic [RW-1:0] rs, logic [RW-1:0] rt, logic [RW-1:0] rd,
                                logic [DW-1:0] imm, logic e_stall, logic e_valid, logic e_regw,
                                logic e_memr, logic [RW-1:0] e_dst, logic [DW-1:0] e_imm,
                                logic [CW-1:0] e_cnt);
        vec_t r;
        r.name = name; r.v = v; r.fl = fl; r.jump = jump; r.jal = jal; r.regdst = regdst;
        r.memr = memr; r.memw = memw; r.regw = regw; r.alusrc = alusrc;
        r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm;
        r.e_stall = e_stall; r.e_valid = e_valid; r.e_regw = e_regw; r.e_memr = e_memr;
        r.e_dst = e_dst; r.e_imm = e_imm; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t x);
        id_valid = x.v; flush = x.fl; id_jump = x.jump; id_jal = x.jal; id_RegDst = x.regdst;
        id_MemR = x.memr; id_Mem2R = x.memr; id_MemW = x.memw; id_RegW = x.regw;
        id_Alusrc = x.alusrc; id_Branch = 1'b0; id_BNE = 1'b0; id_jr = 1'b0;
        id_ExtOp = 2'd0; id_Aluctrl = 5'd0; id_shamt = 5'd0;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd; id_imm = x.imm;
        id_rs_data = 32'hA000_0000 | DW'(x.rs); id_rt_data = 32'hB000_0000 | DW'(x.rt);
        id_pc4 = 32'h0000_1004;
    endtask

    task automatic step_check(vec_t x);
        drive(x);
        @(negedge clk);
        chk({x.name, ".stall"}, DW'(stall_o), DW'(x.e_stall));
        @(posedge clk); #1;
        chk({x.name, ".valid"}, DW'(ex_valid), DW'(x.e_valid));
        chk({x.name, ".regw"},  DW'(ex_RegW), DW'(x.e_regw));
        chk({x.name, ".memr"},  DW'(ex_MemR), DW'(x.e_memr));
        chk({x.name, ".dst"},   DW'(ex_dst), DW'(x.e_dst));
        chk({x.name, ".imm"},   ex_imm, x.e_imm);
        chk({x.name, ".cnt"},   DW'(bubble_cnt), DW'(x.e_cnt));
    endtask

    initial begin
        vec_t z, fv;
        z = mk("idle", 0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
        drive(z);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", DW'(ex_valid), 0);
        chk("rst.regw", DW'(ex_RegW), 0);
        chk("rst.memr", DW'(ex_MemR), 0);
        chk("rst.dst", DW'(ex_dst), 0);
        chk("rst.cnt", DW'(bubble_cnt), 0);
        chk("rst.stall", DW'(stall_o), 0);
        rst = 1'b0;

        //          name        v fl jp jl rd mr mw rw as  rs rt rd imm      st va rw mr dst eimm     cnt
        t[0]  = mk("addi",      1,0, 0,0,0, 0,0,1,1,  1,5,0,32'h10,  0,1,1,0,5,32'h10,0);
        t[1]  = mk("lw8",       1,0, 0,0,0, 1,0,1,1,  2,8,0,32'h4,   0,1,1,1,8,32'h4,1'b0);
        t[2]  = mk("add_haz",   1,0, 0,0,1, 0,0,1,0,  8,3,9,32'h0,   1,0,0,0,0,32'h0,1);
        t[3]  = mk("add_go",    1,0, 0,0,1, 0,0,1,0,  8,3,9,32'h0,   0,1,1,0,9,32'h0,1);
        t[4]  = mk("lw0",       1,0, 0,0,0, 1,0,1,1,  2,0,0,32'h8,   0,1,1,1,0,32'h8,1);
        t[5]  = mk("use0",      1,0, 0,0,1, 0,0,1,0,  0,0,10,32'h0,  0,1,1,0,10,32'h0,1);
        t[6]  = mk("lw8b",      1,0, 0,0,0, 1,0,1,1,  2,8,0,32'hC,   0,1,1,1,8,32'hC,1);
        t[7]  = mk("j",         1,0, 1,0,0, 0,0,0,0,  8,8,0,32'h40,  0,1,0,0,8,32'h40,1);
        t[8]  = mk("lw8c",      1,0, 0,0,0, 1,0,1,1,  2,8,0,32'h10,  0,1,1,1,8,32'h10,1);
        t[9]  = mk("flush_haz", 1,1, 0,0,1, 0,0,1,0,  8,3,9,32'h0,   0,0,0,0,0,32'h0,2);
        t[10] = mk("jal",       1,0, 1,1,0, 0,0,1,0,  0,7,0,32'h80,  0,1,1,0,31,32'h80,2);
        t[11] = mk("lw9",       1,0, 0,0,0, 1,0,1,1,  2,9,0,32'h14,  0,1,1,1,9,32'h14,2);
        t[12] = mk("sw_haz",    1,0, 0,0,0, 0,1,0,1,  4,9,0,32'h0,   1,0,0,0,0,32'h0,3);
        t[13] = mk("sw_go",     1,0, 0,0,0, 0,1,0,1,  4,9,0,32'h0,   0,1,0,0,9,32'h0,3);
        t[14] = mk("invalid",   0,0, 0,0,0, 1,0,1,0,  0,5,0,32'h0,   0,0,0,0,5,32'h0,3);
        for (int i = 0; i < 15; i++) step_check(t[i]);

        // Saturation: five flushes from a fresh reset must stop at 3.
        drive(z);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fv = mk("sat", 1,1, 0,0,0, 0,0,1,0, 1,2,3,32'h0, 0,0,0,0,0,32'h0, (i < 3) ? CW'(i + 1) : CW'(3));
            step_check(fv);
        end

        // Reset arriving while a load-use stall is active.
        step_check(mk("mid_lw", 1,0, 0,0,0, 1,0,1,1, 2,8,0,32'h4, 0,1,1,1,8,32'h4,3));
        drive(t[2]);
        @(negedge clk);
        chk("mid.stall_before", DW'(stall_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid.valid", DW'(ex_valid), 0);
        chk("mid.stall_after", DW'(stall_o), 0);
        chk("mid.cnt", DW'(bubble_cnt), 0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
